// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - FIFO-buffered UART transmit serializer with configurable framing
// One bit per baud_tick; config is latched at each frame start so mid-frame changes wait a frame.
module uart_tx_serializer #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_tick,
  input  logic              tx_en,
  input  logic [3:0]        data_len,
  input  logic [2:0]        parity_mode,
  input  logic              stop_bits,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done,
  output logic [CNT_W-1:0]  fifo_count
);

  localparam int         PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [3:0] MAX_LEN = 4'(DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  state_t            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [3:0]        bit_idx_q;
  logic [3:0]        len_q;
  logic              par_en_q;
  logic              par_bit_q;
  logic              stop2_q;
  logic              stop_idx_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;

  logic [DATA_W-1:0] head;
  logic [3:0]        eff_len;
  logic              eff_par_en;
  logic              eff_par_bit;
  logic              par_x;
  logic              push;
  logic              pop;
  logic              last_stop;
  logic              frame_end;

  assign in_ready   = (count_q != CNT_W'(FIFO_DEPTH));
  assign fifo_count = count_q;
  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

  assign head      = mem_q[rd_ptr_q];
  assign push      = in_valid && in_ready;
  assign last_stop = (state_q == S_STOP) && (!stop2_q || stop_idx_q);
  assign frame_end = baud_tick && last_stop;
  // A new frame may start from IDLE or directly out of the final stop bit.
  assign pop       = baud_tick && tx_en && (count_q != '0) &&
                     ((state_q == S_IDLE) || last_stop);

  // Effective framing for the word about to be popped.
  always_comb begin
    eff_len = data_len;
    if (data_len < 4'd5) begin
      eff_len = 4'd5;
    end else if (data_len > MAX_LEN) begin
      eff_len = MAX_LEN;
    end
    par_x = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (4'(i) < eff_len) par_x = par_x ^ head[i];
    end
    eff_par_en  = 1'b1;
    eff_par_bit = 1'b0;
    case (parity_mode)
      3'b001:  eff_par_bit = par_x;
      3'b010:  eff_par_bit = ~par_x;
      3'b011:  eff_par_bit = 1'b1;
      3'b100:  eff_par_bit = 1'b0;
      default: eff_par_en  = 1'b0;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      len_q      <= 4'd5;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= frame_end;
      if (pop) begin
        shift_q   <= head;
        len_q     <= eff_len;
        par_en_q  <= eff_par_en;
        par_bit_q <= eff_par_bit;
        stop2_q   <= stop_bits;
        tx_q      <= 1'b0;
        busy_q    <= 1'b1;
        state_q   <= S_START;
      end else if (baud_tick) begin
        case (state_q)
          S_START: begin
            tx_q      <= shift_q[0];
            bit_idx_q <= '0;
            state_q   <= S_DATA;
          end
          S_DATA: begin
            if (bit_idx_q != len_q - 4'd1) begin
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + 4'd1;
            end else if (par_en_q) begin
              tx_q    <= par_bit_q;
              state_q <= S_PARITY;
            end else begin
              tx_q       <= 1'b1;
              stop_idx_q <= 1'b0;
              state_q    <= S_STOP;
            end
          end
          S_PARITY: begin
            tx_q       <= 1'b1;
            stop_idx_q <= 1'b0;
            state_q    <= S_STOP;
          end
          S_STOP: begin
            if (!last_stop) begin
              stop_idx_q <= 1'b1;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - directed self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       tx_en = 1'b1;
  logic [3:0] data_len = 4'd8;
  logic [2:0] parity_mode = 3'b000;
  logic       stop_bits = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;
  logic [2:0] fifo_count;

  int total = 0;
  int bad = 0;

  uart_tx_serializer #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_en(tx_en),
    .data_len(data_len), .parity_mode(parity_mode), .stop_bits(stop_bits),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Expected line values of one frame, bit i = value driven after the i-th tick.
  function automatic logic [15:0] frm(input logic [7:0] d, input int len,
                                      input logic [2:0] pm, input logic s2,
                                      output int n);
    logic [15:0] b;
    logic p;
    int k;
    b = 16'hFFFF;
    b[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < len; i++) begin
      b[1+i] = d[i];
      p = p ^ d[i];
    end
    k = 1 + len;
    if (pm == 3'b001) begin b[k] = p; k++; end
    else if (pm == 3'b010) begin b[k] = ~p; k++; end
    else if (pm == 3'b011) begin b[k] = 1'b1; k++; end
    else if (pm == 3'b100) begin b[k] = 1'b0; k++; end
    n = k + (s2 ? 2 : 1);
    return b;
  endfunction

  task automatic tick();
    @(negedge clk); baud_tick = 1'b1;
    @(negedge clk); baud_tick = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk); in_data = d; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", tx_done); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_frame_a5();
    logic [15:0] e;
    e = 16'b00000_10101001010;
    data_len = 4'd8; parity_mode = 3'b001; stop_bits = 1'b0;
    push(8'hA5);
    for (int t = 0; t < 11; t++) begin
      tick();
      total++; if (tx !== e[t]) begin bad++; $display("FAIL a5_tx t=%0d got=%b exp=%b", t, tx, e[t]); end
      total++; if (tx_busy !== 1'b1 || tx_done !== 1'b0) begin bad++; $display("FAIL a5_busy t=%0d busy=%b done=%b exp=1/0", t, tx_busy, tx_done); end
    end
    tick();
    total++; if (tx_done !== 1'b1 || tx_busy !== 1'b0 || tx !== 1'b1) begin bad++; $display("FAIL a5_end done=%b busy=%b tx=%b exp=1/0/1", tx_done, tx_busy, tx); end
    @(negedge clk);
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL a5_done_pulse got=%b exp=0", tx_done); end
  endtask

  task automatic test_frame_13();
    logic [15:0] e;
    e = 16'b0000000_110100110;
    data_len = 4'd5; parity_mode = 3'b010; stop_bits = 1'b1;
    push(8'h13);
    for (int t = 0; t < 9; t++) begin
      tick();
      total++; if (tx !== e[t] || tx_done !== 1'b0) begin bad++; $display("FAIL f13_tx t=%0d got=%b done=%b exp=%b/0", t, tx, tx_done, e[t]); end
    end
    tick();
    total++; if (tx_done !== 1'b1 || tx_busy !== 1'b0) begin bad++; $display("FAIL f13_end done=%b busy=%b exp=1/0", tx_done, tx_busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [4];
    logic [15:0] e;
    int n, dcnt;
    w[0] = 8'h3C; w[1] = 8'h81; w[2] = 8'hFF; w[3] = 8'h5A;
    data_len = 4'd8; parity_mode = 3'b000; stop_bits = 1'b0;
    for (int i = 0; i < 4; i++) push(w[i]);
    total++; if (in_ready !== 1'b0 || fifo_count !== 3'd4) begin bad++; $display("FAIL b2b_full ready=%b count=%0d exp=0/4", in_ready, fifo_count); end
    push(8'hEE);
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL b2b_drop count=%0d exp=4", fifo_count); end
    dcnt = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      e = frm(w[t/10], 8, 3'b000, 1'b0, n);
      if (tx_done === 1'b1) dcnt++;
      total++; if (tx !== e[t%10]) begin bad++; $display("FAIL b2b_tx t=%0d got=%b exp=%b", t, tx, e[t%10]); end
      total++; if (tx_done !== ((t % 10 == 0) && (t > 0)) || tx_busy !== 1'b1) begin bad++; $display("FAIL b2b_ctl t=%0d done=%b busy=%b", t, tx_done, tx_busy); end
    end
    tick();
    if (tx_done === 1'b1) dcnt++;
    total++; if (dcnt !== 4) begin bad++; $display("FAIL b2b_dones got=%0d exp=4", dcnt); end
    total++; if (fifo_count !== 3'd0 || tx_busy !== 1'b0 || tx !== 1'b1) begin bad++; $display("FAIL b2b_end count=%0d busy=%b tx=%b exp=0/0/1", fifo_count, tx_busy, tx); end
  endtask

  task automatic test_reset_mid();
    data_len = 4'd8; parity_mode = 3'b000; stop_bits = 1'b0;
    push(8'h00); push(8'h11); push(8'h22); push(8'h33);
    repeat (3) tick();
    total++; if (fifo_count !== 3'd3 || tx !== 1'b0 || tx_busy !== 1'b1) begin bad++; $display("FAIL rmid_pre count=%0d tx=%b busy=%b exp=3/0/1", fifo_count, tx, tx_busy); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 3'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL rmid_async tx=%b busy=%b count=%0d ready=%b exp=1/0/0/1", tx, tx_busy, fifo_count, in_ready); end
    @(negedge clk); rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      total++; if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 3'd0) begin bad++; $display("FAIL rmid_after t=%0d tx=%b busy=%b count=%0d exp=1/0/0", t, tx, tx_busy, fifo_count); end
    end
  endtask

  task automatic test_cfg_change();
    logic [15:0] e;
    int n;
    data_len = 4'd8; parity_mode = 3'b001; stop_bits = 1'b0;
    push(8'hC6); push(8'h2B);
    e = frm(8'hC6, 8, 3'b001, 1'b0, n);
    for (int t = 0; t < n; t++) begin
      tick();
      total++; if (tx !== e[t]) begin bad++; $display("FAIL cfg_f1 t=%0d got=%b exp=%b", t, tx, e[t]); end
      if (t == 3) begin data_len = 4'd6; parity_mode = 3'b000; end
    end
    tick();
    total++; if (tx_done !== 1'b1 || tx !== 1'b0 || tx_busy !== 1'b1) begin bad++; $display("FAIL cfg_turn done=%b tx=%b busy=%b exp=1/0/1", tx_done, tx, tx_busy); end
    e = frm(8'h2B, 6, 3'b000, 1'b0, n);
    for (int t = 1; t < n; t++) begin
      tick();
      total++; if (tx !== e[t] || tx_done !== 1'b0) begin bad++; $display("FAIL cfg_f2 t=%0d got=%b done=%b exp=%b/0", t, tx, tx_done, e[t]); end
    end
    tick();
    total++; if (tx_done !== 1'b1 || tx_busy !== 1'b0) begin bad++; $display("FAIL cfg_end done=%b busy=%b exp=1/0", tx_done, tx_busy); end
  endtask

  task automatic test_tx_en();
    data_len = 4'd8; parity_mode = 3'b000; stop_bits = 1'b0;
    push(8'h0F); push(8'hF0);
    tick();
    tick();
    tx_en = 1'b0;
    repeat (8) tick();
    tick();
    total++; if (tx_done !== 1'b1 || tx_busy !== 1'b0 || tx !== 1'b1 || fifo_count !== 3'd1) begin bad++; $display("FAIL txen_end done=%b busy=%b tx=%b count=%0d exp=1/0/1/1", tx_done, tx_busy, tx, fifo_count); end
    for (int t = 0; t < 3; t++) begin
      tick();
      total++; if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 3'd1) begin bad++; $display("FAIL txen_hold t=%0d tx=%b busy=%b count=%0d exp=1/0/1", t, tx, tx_busy, fifo_count); end
    end
    tx_en = 1'b1;
    tick();
    total++; if (tx !== 1'b0 || tx_busy !== 1'b1 || fifo_count !== 3'd0) begin bad++; $display("FAIL txen_resume tx=%b busy=%b count=%0d exp=0/1/0", tx, tx_busy, fifo_count); end
    repeat (9) tick();
    tick();
    total++; if (tx_done !== 1'b1 || tx_busy !== 1'b0) begin bad++; $display("FAIL txen_f2 done=%b busy=%b exp=1/0", tx_done, tx_busy); end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_frame_13();
    test_back_to_back();
    test_reset_mid();
    test_cfg_change();
    test_tx_en();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
